// File: rtl/wrarb_pkg.sv
// Shared types and helpers for the async FIFO write-side arbiter.
// Optional burst limiting is enabled by defining WRARB_MAX_BURST_EN.
package wrarb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } wrarb_state_t;

    localparam int WRARB_MAX_REQ = 8;
    localparam int WRARB_GID_W   = $clog2(WRARB_MAX_REQ);

    function automatic int rr_next(input int ptr, input int n);
        return (ptr >= n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/wrarb_rr_picker.sv
// Combinational circular-priority picker: first set req bit at or after rr_ptr.
// Shared between the write-side and read-side schedulers.
module wrarb_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic               found,
    output logic [IW-1:0]      idx
);
    import wrarb_pkg::*;

    localparam int CW = WRARB_GID_W + 1;

    logic [CW-1:0] cand;

    // Walk from the farthest candidate back to rr_ptr so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = CW'(rr_ptr) + CW'(k);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (req[cand[IW-1:0]]) begin
                found = 1'b1;
                idx   = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// Packet-locked round-robin scheduler for the async FIFO write port (wrclk domain).
// Define WRARB_MAX_BURST_EN to force a grant release after MAX_BURST beats.
module async_fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                        wrclk,
    input  logic                        wrst_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_rdy,
    input  logic                        fifo_full,
    output logic                        fifo_wr_en,
    output logic [DATA_W-1:0]           fifo_wdata,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
`ifdef WRARB_MAX_BURST_EN
    output logic                        burst_cut,
`endif
    output logic                        busy
);
    import wrarb_pkg::*;

    localparam int GW = $clog2(NUM_REQ);

    wrarb_state_t  state, state_nxt;
    logic [GW-1:0] rr_ptr, rr_nxt, grant_nxt;
    logic [GW-1:0] pick_idx;
    logic          pick_found;
    logic          accept, done, cut;

    wrarb_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IW      (GW)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .idx    (pick_idx)
    );

`ifdef WRARB_MAX_BURST_EN
    localparam int BW = $clog2(MAX_BURST) + 1;

    logic [BW-1:0] beat_cnt;

    // The MAX_BURST-th accepted beat closes the grant even without req_last.
    assign cut = (beat_cnt == BW'(MAX_BURST - 1));

    always_ff @(posedge wrclk or negedge wrst_n) begin
        if (!wrst_n) begin
            beat_cnt  <= '0;
            burst_cut <= 1'b0;
        end else begin
            burst_cut <= done && !req_last[grant_id];
            if (done) begin
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end
`else
    logic [31:0] unused_max_burst;

    assign unused_max_burst = MAX_BURST;
    assign cut              = 1'b0;
`endif

    assign accept = (state == LOCK) && req[grant_id] && !fifo_full;
    assign done   = accept && (req_last[grant_id] || cut);
    assign busy   = (state == LOCK);

    always_ff @(posedge wrclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
        end else begin
            state    <= state_nxt;
            grant_id <= grant_nxt;
            rr_ptr   <= rr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        grant_nxt  = grant_id;
        rr_nxt     = rr_ptr;
        req_rdy    = '0;
        fifo_wr_en = 1'b0;
        fifo_wdata = '0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = LOCK;
                    grant_nxt = pick_idx;
                end
            end
            LOCK: begin
                if (accept) begin
                    req_rdy[grant_id] = 1'b1;
                    fifo_wr_en        = 1'b1;
                    fifo_wdata        = req_data[grant_id*DATA_W +: DATA_W];
                end
                if (done) begin
                    state_nxt = IDLE;
                    rr_nxt    = GW'(rr_next(int'(grant_id), NUM_REQ));
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Directed self-checking bench for async_fifo_wr_arbiter (NUM_REQ=4, DATA_W=8).
// Burst-cut checks are compiled in when WRARB_MAX_BURST_EN is defined.
module tb_async_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;

    logic                       wrclk = 1'b0;
    logic                       wrst_n;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         req_last;
    logic [NUM_REQ-1:0]         req_rdy;
    logic                       fifo_full;
    logic                       fifo_wr_en;
    logic [DATA_W-1:0]          fifo_wdata;
    logic [1:0]                 grant_id;
    logic                       busy;
`ifdef WRARB_MAX_BURST_EN
    logic                       burst_cut;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;

    always #5 wrclk = ~wrclk;

    async_fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .wrclk      (wrclk),
        .wrst_n     (wrst_n),
        .req        (req),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_rdy    (req_rdy),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_wdata (fifo_wdata),
        .grant_id   (grant_id),
`ifdef WRARB_MAX_BURST_EN
        .burst_cut  (burst_cut),
`endif
        .busy       (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Write monitor, sampled mid-cycle on the falling edge.
    always @(negedge wrclk) begin
        if (wrst_n && fifo_wr_en) begin
            n_writes++;
            if (fifo_full) check_val("wr_while_full", 32'(fifo_wr_en), 32'd0);
        end
    end

    task automatic tick();
        @(posedge wrclk);
        #2;
    endtask

    task automatic set_req(input int id, input logic v, input logic [7:0] d, input logic last);
        req[id]               = v;
        req_data[id*8 +: 8]   = d;
        req_last[id]          = last;
    endtask

    task automatic check_quiet(input string tag);
        #1;
        check_val({tag, "_wr_en"}, 32'(fifo_wr_en), 32'd0);
        check_val({tag, "_rdy"},   32'(req_rdy),    32'd0);
    endtask

    task automatic idle_gap();
        check_quiet("idle");
        check_val("idle_busy", 32'(busy), 32'd0);
        tick();
    endtask

    task automatic beat(input int id, input logic [7:0] d, input logic last);
        set_req(id, 1'b1, d, last);
        #1;
        check_val("beat_wr_en", 32'(fifo_wr_en), 32'd1);
        check_val("beat_wdata", 32'(fifo_wdata), 32'(d));
        check_val("beat_rdy",   32'(req_rdy),    32'(1 << id));
        check_val("beat_owner", 32'(grant_id),   32'(id));
        tick();
    endtask

    initial begin
        int exp_writes;
        int seq3 [5];
        seq3 = '{0, 1, 2, 3, 0};
        exp_writes = 0;

        wrst_n    = 1'b0;
        req       = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        #1;
        check_val("rst_busy",  32'(busy),       32'd0);
        check_val("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        check_val("rst_rdy",   32'(req_rdy),    32'd0);
        check_val("rst_grant", 32'(grant_id),   32'd0);
        check_val("rst_wdata", 32'(fifo_wdata), 32'd0);
        tick();
        tick();
        wrst_n = 1'b1;
        for (int i = 0; i < 10; i++) idle_gap();

        // Two 3-beat packets from requesters 0 and 2.
        set_req(0, 1'b1, 8'h10, 1'b0);
        set_req(2, 1'b1, 8'h20, 1'b0);
        idle_gap();
        check_val("t2_busy", 32'(busy), 32'd1);
        beat(0, 8'h10, 1'b0);
        beat(0, 8'h11, 1'b0);
        beat(0, 8'h12, 1'b1);
        set_req(0, 1'b0, 8'h00, 1'b0);
        idle_gap();
        check_val("t2_grant2", 32'(grant_id), 32'd2);
        beat(2, 8'h20, 1'b0);
        beat(2, 8'h21, 1'b0);
        beat(2, 8'h22, 1'b1);
        set_req(2, 1'b0, 8'h00, 1'b0);
        exp_writes += 6;

        // Reset in the middle of a locked packet.
        set_req(1, 1'b1, 8'h99, 1'b0);
        idle_gap();
        check_val("mid_rst_pre_busy",  32'(busy),     32'd1);
        check_val("mid_rst_pre_grant", 32'(grant_id), 32'd1);
        #1;
        check_val("mid_rst_pre_wr", 32'(fifo_wr_en), 32'd1);
        wrst_n = 1'b0;
        #1;
        check_val("mid_rst_busy",  32'(busy),       32'd0);
        check_val("mid_rst_wr_en", 32'(fifo_wr_en), 32'd0);
        check_val("mid_rst_rdy",   32'(req_rdy),    32'd0);
        check_val("mid_rst_grant", 32'(grant_id),   32'd0);
        set_req(1, 1'b0, 8'h00, 1'b0);
        tick();
        wrst_n = 1'b1;
        tick();

        // All four requesting 1-beat packets: 0,1,2,3,0.
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'hA0 + 8'(i), 1'b1);
        foreach (seq3[j]) begin
            idle_gap();
            beat(seq3[j], 8'hA0 + 8'(seq3[j]), 1'b1);
        end
        req = '0;
        req_last = '0;
        exp_writes += 5;

        // Owner 1 stalled by fifo_full for 5 cycles, last beat pending.
        set_req(1, 1'b1, 8'h30, 1'b0);
        idle_gap();
        beat(1, 8'h30, 1'b0);
        fifo_full = 1'b1;
        set_req(1, 1'b1, 8'h31, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check_quiet("full");
            check_val("full_busy",  32'(busy),     32'd1);
            check_val("full_owner", 32'(grant_id), 32'd1);
            tick();
        end
        fifo_full = 1'b0;
        beat(1, 8'h31, 1'b1);
        set_req(1, 1'b0, 8'h00, 1'b0);
        exp_writes += 2;

        // Owner 2 drops req mid-packet while 0 waits; then 3 precedes 0.
        set_req(2, 1'b1, 8'h40, 1'b0);
        set_req(0, 1'b1, 8'h55, 1'b1);
        idle_gap();
        beat(2, 8'h40, 1'b0);
        for (int i = 0; i < 3; i++) begin
            set_req(2, 1'b0, 8'h41, 1'b1);
            check_quiet("drop");
            check_val("drop_owner", 32'(grant_id), 32'd2);
            check_val("drop_busy",  32'(busy),     32'd1);
            tick();
        end
        beat(2, 8'h41, 1'b1);
        set_req(2, 1'b0, 8'h00, 1'b0);
        set_req(3, 1'b1, 8'h60, 1'b1);
        idle_gap();
        check_val("rr3_grant", 32'(grant_id), 32'd3);
        beat(3, 8'h60, 1'b1);
        set_req(3, 1'b0, 8'h00, 1'b0);
        idle_gap();
        check_val("rr0_grant", 32'(grant_id), 32'd0);
        beat(0, 8'h55, 1'b1);
        set_req(0, 1'b0, 8'h00, 1'b0);
        exp_writes += 4;

`ifdef WRARB_MAX_BURST_EN
        // 10-beat packet on requester 0 with MAX_BURST=4: grants of 4, 4, 2.
        for (int g = 0; g < 3; g++) begin
            set_req(0, 1'b1, 8'h70 + 8'(g * 4), 1'b0);
            check_val("cut_pulse", 32'(burst_cut), (g > 0) ? 32'd1 : 32'd0);
            idle_gap();
            check_val("cut_grant", 32'(grant_id), 32'd0);
            for (int b = 0; b < ((g < 2) ? 4 : 2); b++) begin
                check_val("cut_quiet", 32'(burst_cut), 32'd0);
                beat(0, 8'h70 + 8'(g * 4 + b), (g * 4 + b) == 9);
            end
        end
        set_req(0, 1'b0, 8'h00, 1'b0);
        #1;
        check_val("cut_natural_end", 32'(burst_cut), 32'd0);
        exp_writes += 10;
`endif

        tick();
        tick();
        check_val("write_count", 32'(n_writes), 32'(exp_writes));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
